// File: rtl/noc_to_cpu_deflitizer_pkg.sv
// Shared NoC/CPU flit types, widths and the flit checksum function.
// Used by both the egress deflitizer and the ingress flitizer.
package types;

  localparam int FLIT_WIDTH     = 128;
  localparam int CPU_WORD_WIDTH = 32;
  localparam int WORDS_PER_FLIT = 4;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } deflit_state_e;

  // XOR of bytes 15..1; byte 0 of a good flit carries this value.
  function automatic logic [7:0] flit_checksum(input flit_t flit);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 1; i < FLIT_WIDTH / 8; i++) begin
      sum = sum ^ flit[i*8 +: 8];
    end
    return sum;
  endfunction

endpackage

// File: rtl/noc_to_cpu_deflitizer_if.sv
// Flit-in / word-out handshake bundle between the NoC ejection port,
// the deflitizer and the CPU.
interface noc_to_cpu_deflitizer_if;
  import types::*;

  flit_t       popped_flit;
  logic        popped_flit_valid;
  logic        popped_flit_ready;
  logic [31:0] data_out;
  logic        data_out_vld;
  logic        data_out_rdy;
  logic        data_out_last;

  // Environment side: NoC router pushes flits, CPU consumes words.
  modport master (
    output popped_flit, popped_flit_valid, data_out_rdy,
    input  popped_flit_ready, data_out, data_out_vld, data_out_last
  );

  // Deflitizer side.
  modport slave (
    input  popped_flit, popped_flit_valid, data_out_rdy,
    output popped_flit_ready, data_out, data_out_vld, data_out_last
  );

endinterface

// File: rtl/noc_to_cpu_deflitizer_checksum.sv
// Purely combinational flit checksum checker, shared by ingress and
// egress bridges.
module flit_checksum_check_comb
  import types::*;
(
  input  flit_t flit,
  output logic  is_valid
);

  assign is_valid = (flit[7:0] == flit_checksum(flit));

endmodule

// File: rtl/noc_to_cpu_deflitizer.sv
// NoC-to-CPU egress bridge: checks each ejected flit and serialises good
// flits as four 32-bit words (LSW first); bad flits are counted and dropped.
module noc_to_cpu_deflitizer
  import types::*;
(
  input  logic                          nocclk,
  input  logic                          rst,
  noc_to_cpu_deflitizer_if.slave        bus,
  output logic                          sys_invalid_flit,
  output logic [7:0]                    dropped_flit_count
);

  deflit_state_e state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  flit_t         buf_q, buf_d;
  logic          invalid_q, invalid_d;
  logic [7:0]    count_q, count_d;

  logic          flit_good;
  logic          in_send;
  logic          word_hs;
  logic          last_hs;
  logic          flit_accept;

  flit_checksum_check_comb u_checksum (
    .flit     (bus.popped_flit),
    .is_valid (flit_good)
  );

  assign in_send     = (state_q == ST_SEND);
  assign word_hs     = in_send & bus.data_out_rdy;
  assign last_hs     = word_hs & (idx_q == 2'd3);
  // Ready looks only at state and CPU rdy, never at popped_flit_valid.
  assign bus.popped_flit_ready = ~in_send | last_hs;
  assign flit_accept = bus.popped_flit_ready & bus.popped_flit_valid;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    invalid_d = invalid_q;
    count_d   = count_q;

    case (state_q)
      ST_IDLE: ;
      ST_SEND: begin
        if (word_hs) begin
          idx_d = idx_q + 2'd1;
          if (last_hs) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A flit can only be accepted in IDLE or on the last-word edge,
    // so a good one always (re)starts SEND and a bad one leaves us in IDLE.
    if (flit_accept) begin
      if (flit_good) begin
        buf_d   = bus.popped_flit;
        idx_d   = 2'd0;
        state_d = ST_SEND;
      end else begin
        invalid_d = 1'b1;
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge nocclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      buf_q     <= '0;
      invalid_q <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      invalid_q <= invalid_d;
      count_q   <= count_d;
    end
  end

  assign bus.data_out      = buf_q[{idx_q, 5'd0} +: 32];
  assign bus.data_out_vld  = in_send;
  assign bus.data_out_last = in_send & (idx_q == 2'd3);

  assign sys_invalid_flit   = invalid_q;
  assign dropped_flit_count = count_q;

endmodule

// File: tb/tb_noc_to_cpu_deflitizer.sv
// Self-checking bench for noc_to_cpu_deflitizer: directed scenarios plus a
// randomized run scored against a word-queue model of the bridge.
module tb_noc_to_cpu_deflitizer;

  logic nocclk;
  logic rst;
  logic sys_invalid_flit;
  logic [7:0] dropped_flit_count;

  int checks;
  int failures;

  localparam logic [127:0] FLIT_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] FLIT_B = 128'h0F0E0D0C_0B0A0908_07060504_03021110;
  localparam logic [127:0] FLIT_BAD = 128'h0F0E0D0C_0B0A0908_07060504_03020101;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_word_t;

  noc_to_cpu_deflitizer_if bus ();

  noc_to_cpu_deflitizer dut (
    .nocclk             (nocclk),
    .rst                (rst),
    .bus                (bus),
    .sys_invalid_flit   (sys_invalid_flit),
    .dropped_flit_count (dropped_flit_count)
  );

  initial nocclk = 1'b0;
  always #5 nocclk = ~nocclk;

  // A flit is good when all 16 bytes XOR to zero.
  function automatic bit flit_ok(input logic [127:0] f);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 16; i++) x = x ^ f[i*8 +: 8];
    return x == 8'h00;
  endfunction

  function automatic logic [127:0] make_good(input logic [127:0] f);
    logic [127:0] g;
    logic [7:0] x;
    g = f;
    g[7:0] = 8'h00;
    x = 8'h00;
    for (int i = 0; i < 16; i++) x = x ^ g[i*8 +: 8];
    g[7:0] = x;
    return g;
  endfunction

  task automatic tick();
    @(posedge nocclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.popped_flit_valid = 1'b0;
    bus.popped_flit = '0;
    bus.data_out_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.popped_flit_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.popped_flit_ready);
    end
    checks++;
    if (bus.data_out_vld !== 1'b0 || bus.data_out_last !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_vld_last got=%b%b exp=00", bus.data_out_vld, bus.data_out_last);
    end
    checks++;
    if (bus.data_out !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_data got=%h exp=00000000", bus.data_out);
    end
    checks++;
    if (sys_invalid_flit !== 1'b0 || dropped_flit_count !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_err got=%b/%h exp=0/00", sys_invalid_flit, dropped_flit_count);
    end
  endtask

  task automatic test_single_good();
    logic [31:0] words [4];
    words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    do_reset();
    bus.popped_flit = FLIT_A;
    bus.popped_flit_valid = 1'b1;
    bus.data_out_rdy = 1'b1;
    tick();
    bus.popped_flit_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (bus.data_out_vld !== 1'b1 || bus.data_out !== words[w]) begin
        failures++; $display("[TB] FAIL single_word%0d got=%b/%h exp=1/%h", w, bus.data_out_vld, bus.data_out, words[w]);
      end
      checks++;
      if (bus.data_out_last !== (w == 3) || bus.popped_flit_ready !== (w == 3)) begin
        failures++; $display("[TB] FAIL single_last_ready%0d got=%b%b exp=%b%b", w, bus.data_out_last, bus.popped_flit_ready, w == 3, w == 3);
      end
      tick();
    end
    checks++;
    if (bus.data_out_vld !== 1'b0 || sys_invalid_flit !== 1'b0) begin
      failures++; $display("[TB] FAIL single_end got vld=%b err=%b exp=0/0", bus.data_out_vld, sys_invalid_flit);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [4];
    logic pattern [7];
    int w;
    words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    bus.popped_flit = FLIT_A;
    bus.popped_flit_valid = 1'b1;
    bus.data_out_rdy = 1'b1;
    tick();
    bus.popped_flit_valid = 1'b0;
    w = 0;
    for (int i = 0; i < 7; i++) begin
      bus.data_out_rdy = pattern[i];
      #1;
      checks++;
      if (bus.data_out_vld !== 1'b1 || bus.data_out !== words[w]) begin
        failures++; $display("[TB] FAIL bp_word cyc%0d got=%b/%h exp=1/%h", i, bus.data_out_vld, bus.data_out, words[w]);
      end
      checks++;
      if (bus.popped_flit_ready !== (w == 3 && pattern[i])) begin
        failures++; $display("[TB] FAIL bp_ready cyc%0d got=%b exp=%b", i, bus.popped_flit_ready, w == 3 && pattern[i]);
      end
      if (pattern[i]) w++;
      tick();
    end
    checks++;
    if (bus.data_out_vld !== 1'b0) begin
      failures++; $display("[TB] FAIL bp_end_vld got=%b exp=0", bus.data_out_vld);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] flits [2];
    logic [31:0] exp;
    flits = '{FLIT_A, FLIT_B};
    do_reset();
    bus.popped_flit = FLIT_A;
    bus.popped_flit_valid = 1'b1;
    bus.data_out_rdy = 1'b1;
    tick();
    bus.popped_flit = FLIT_B;
    for (int c = 0; c < 8; c++) begin
      exp = flits[c/4][(c%4)*32 +: 32];
      checks++;
      if (bus.data_out_vld !== 1'b1 || bus.data_out !== exp || bus.data_out_last !== (c % 4 == 3)) begin
        failures++; $display("[TB] FAIL b2b_word%0d got=%b/%h/%b exp=1/%h/%b", c, bus.data_out_vld, bus.data_out, bus.data_out_last, exp, c % 4 == 3);
      end
      checks++;
      if (bus.popped_flit_ready !== (c % 4 == 3)) begin
        failures++; $display("[TB] FAIL b2b_ready%0d got=%b exp=%b", c, bus.popped_flit_ready, c % 4 == 3);
      end
      tick();
      if (c == 3) bus.popped_flit_valid = 1'b0;
    end
    checks++;
    if (bus.data_out_vld !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_end_vld got=%b exp=0", bus.data_out_vld);
    end
  endtask

  task automatic test_bad_checksum();
    logic [31:0] words [4];
    words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    do_reset();
    bus.popped_flit = FLIT_BAD;
    bus.popped_flit_valid = 1'b1;
    bus.data_out_rdy = 1'b1;
    #1;
    checks++;
    if (bus.popped_flit_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL bad_ready got=%b exp=1", bus.popped_flit_ready);
    end
    tick();
    bus.popped_flit = FLIT_A;
    checks++;
    if (bus.data_out_vld !== 1'b0 || sys_invalid_flit !== 1'b1 || dropped_flit_count !== 8'd1) begin
      failures++; $display("[TB] FAIL bad_drop got=%b/%b/%h exp=0/1/01", bus.data_out_vld, sys_invalid_flit, dropped_flit_count);
    end
    tick();
    bus.popped_flit_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (bus.data_out_vld !== 1'b1 || bus.data_out !== words[w] || sys_invalid_flit !== 1'b1) begin
        failures++; $display("[TB] FAIL bad_follow%0d got=%b/%h/%b exp=1/%h/1", w, bus.data_out_vld, bus.data_out, sys_invalid_flit, words[w]);
      end
      tick();
    end
    checks++;
    if (dropped_flit_count !== 8'd1) begin
      failures++; $display("[TB] FAIL bad_count_hold got=%h exp=01", dropped_flit_count);
    end
  endtask

  task automatic test_saturation();
    int exp;
    do_reset();
    bus.popped_flit = FLIT_BAD;
    bus.popped_flit_valid = 1'b1;
    bus.data_out_rdy = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      tick();
      exp = (i > 255) ? 255 : i;
      checks++;
      if (dropped_flit_count !== exp[7:0] || bus.data_out_vld !== 1'b0) begin
        failures++; $display("[TB] FAIL sat_count%0d got=%h/%b exp=%h/0", i, dropped_flit_count, bus.data_out_vld, exp[7:0]);
      end
    end
    bus.popped_flit_valid = 1'b0;
  endtask

  task automatic test_reset_mid_flit();
    do_reset();
    bus.popped_flit = FLIT_A;
    bus.popped_flit_valid = 1'b1;
    bus.data_out_rdy = 1'b1;
    tick();
    bus.popped_flit_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.data_out !== 32'h0B0A0908) begin
      failures++; $display("[TB] FAIL rmid_pre got=%h exp=0B0A0908", bus.data_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.data_out_vld !== 1'b0 || bus.popped_flit_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL rmid_after got vld=%b rdy=%b exp=0/1", bus.data_out_vld, bus.popped_flit_ready);
    end
    bus.popped_flit = FLIT_B;
    bus.popped_flit_valid = 1'b1;
    tick();
    bus.popped_flit_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (bus.data_out_vld !== 1'b1 || bus.data_out !== FLIT_B[w*32 +: 32]) begin
        failures++; $display("[TB] FAIL rmid_word%0d got=%b/%h exp=1/%h", w, bus.data_out_vld, bus.data_out, FLIT_B[w*32 +: 32]);
      end
      tick();
    end
  endtask

  // Model: pending words of the flit in flight; ready when none pending
  // or only the final word is pending and the CPU takes it now.
  task automatic test_random();
    exp_word_t q [$];
    exp_word_t e;
    logic [127:0] f;
    bit exp_vld, exp_rdy, exp_flag;
    int exp_cnt;
    do_reset();
    exp_flag = 1'b0;
    exp_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      f = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) != 0) f = make_good(f);
      bus.popped_flit = f;
      bus.popped_flit_valid = ($urandom_range(0, 9) < 6);
      bus.data_out_rdy = ($urandom_range(0, 9) < 7);
      #1;
      exp_vld = (q.size() != 0);
      exp_rdy = (q.size() == 0) || (q.size() == 1 && bus.data_out_rdy);
      checks++;
      if (bus.data_out_vld !== exp_vld || bus.popped_flit_ready !== exp_rdy) begin
        failures++; $display("[TB] FAIL rand_hs cyc%0d got vld=%b rdy=%b exp=%b/%b", c, bus.data_out_vld, bus.popped_flit_ready, exp_vld, exp_rdy);
      end
      if (exp_vld) begin
        checks++;
        if (bus.data_out !== q[0].word || bus.data_out_last !== q[0].last) begin
          failures++; $display("[TB] FAIL rand_word cyc%0d got=%h/%b exp=%h/%b", c, bus.data_out, bus.data_out_last, q[0].word, q[0].last);
        end
      end
      checks++;
      if (sys_invalid_flit !== exp_flag || dropped_flit_count !== exp_cnt[7:0]) begin
        failures++; $display("[TB] FAIL rand_err cyc%0d got=%b/%h exp=%b/%h", c, sys_invalid_flit, dropped_flit_count, exp_flag, exp_cnt[7:0]);
      end
      if (exp_vld && bus.data_out_rdy) void'(q.pop_front());
      if (exp_rdy && bus.popped_flit_valid) begin
        if (flit_ok(f)) begin
          for (int w = 0; w < 4; w++) begin
            e.word = f[w*32 +: 32];
            e.last = (w == 3);
            q.push_back(e);
          end
        end else begin
          exp_flag = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
      end
      @(posedge nocclk);
      #1;
    end
    bus.popped_flit_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.popped_flit = '0;
    bus.popped_flit_valid = 1'b0;
    bus.data_out_rdy = 1'b0;
    test_reset();
    test_single_good();
    test_backpressure();
    test_back_to_back();
    test_bad_checksum();
    test_saturation();
    test_reset_mid_flit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
